// File: rtl/pacman_mover.sv
// Pac-Man tile movement controller: resolves joystick pre-turns against the map
// RAM once per step period and publishes the tile position/heading to the renderer.
module pacman_mover #(
    parameter logic [4:0] BORDER_X_MIN = 5'd1,
    parameter logic [4:0] BORDER_X_MAX = 5'd28,
    parameter logic [4:0] BORDER_Y_MIN = 5'd1,
    parameter logic [4:0] BORDER_Y_MAX = 5'd28,
    parameter logic [4:0] START_X      = 5'd14,
    parameter logic [4:0] START_Y      = 5'd23,
    parameter logic [1:0] START_DIR    = 2'd1,
    parameter logic [5:0] MOVE_FRAMES  = 6'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [3:0] joy,
    input  logic       map_wall,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       moving,
    output logic       step
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_ADDR = 3'd1,
        REQ_DATA = 3'd2,
        CUR_ADDR = 3'd3,
        CUR_DATA = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       pend_vld_q, pend_vld_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [1:0] req_dir_q, req_dir_d;
    logic [4:0] map_x_q, map_x_d;
    logic [4:0] map_y_q, map_y_d;
    logic [4:0] xpos_q, xpos_d;
    logic [4:0] ypos_q, ypos_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       step_q, step_d;
    logic       clr_pend_s;
    logic       target_free_s;

    function automatic logic [4:0] adj_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            2'd1:    adj_x = x - 5'd1;
            2'd3:    adj_x = x + 5'd1;
            default: adj_x = x;
        endcase
    endfunction

    function automatic logic [4:0] adj_y(input logic [4:0] y, input logic [1:0] d);
        case (d)
            2'd0:    adj_y = y - 5'd1;
            2'd2:    adj_y = y + 5'd1;
            default: adj_y = y;
        endcase
    endfunction

    function automatic logic in_border(input logic [4:0] x, input logic [4:0] y);
        in_border = (x >= BORDER_X_MIN) && (x <= BORDER_X_MAX) &&
                    (y >= BORDER_Y_MIN) && (y <= BORDER_Y_MAX);
    endfunction

    function automatic logic [1:0] joy_prio(input logic [3:0] j);
        if (j[0]) begin
            joy_prio = 2'd0;
        end else if (j[1]) begin
            joy_prio = 2'd1;
        end else if (j[2]) begin
            joy_prio = 2'd2;
        end else begin
            joy_prio = 2'd3;
        end
    endfunction

    // The address registers always hold the tile being read, so they double as the move target.
    assign target_free_s = !map_wall && in_border(map_x_q, map_y_q);

    // Next-state logic: frame counting, map reads, move decision and pre-turn buffer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        req_dir_d  = req_dir_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        step_d     = 1'b0;
        clr_pend_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (ce) begin
                    if (cnt_q == (MOVE_FRAMES - 6'd1)) begin
                        cnt_d = 6'd0;
                        if (pend_vld_q && (pend_dir_q != dir_q)) begin
                            state_d   = REQ_ADDR;
                            req_dir_d = pend_dir_q;
                            map_x_d   = adj_x(xpos_q, pend_dir_q);
                            map_y_d   = adj_y(ypos_q, pend_dir_q);
                        end else begin
                            // A request for the heading already taken is simply consumed.
                            state_d    = CUR_ADDR;
                            clr_pend_s = pend_vld_q;
                            map_x_d    = adj_x(xpos_q, dir_q);
                            map_y_d    = adj_y(ypos_q, dir_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            REQ_ADDR: begin
                state_d = REQ_DATA;
            end
            REQ_DATA: begin
                if (target_free_s) begin
                    state_d    = IDLE;
                    xpos_d     = map_x_q;
                    ypos_d     = map_y_q;
                    dir_d      = req_dir_q;
                    moving_d   = 1'b1;
                    step_d     = 1'b1;
                    clr_pend_s = 1'b1;
                end else begin
                    state_d = CUR_ADDR;
                    map_x_d = adj_x(xpos_q, dir_q);
                    map_y_d = adj_y(ypos_q, dir_q);
                end
            end
            CUR_ADDR: begin
                state_d = CUR_DATA;
            end
            CUR_DATA: begin
                state_d = IDLE;
                if (target_free_s) begin
                    xpos_d   = map_x_q;
                    ypos_d   = map_y_q;
                    moving_d = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    moving_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh press always wins over a clear issued in the same cycle.
        if (|joy) begin
            pend_vld_d = 1'b1;
            pend_dir_d = joy_prio(joy);
        end else if (clr_pend_s) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= 2'd0;
            req_dir_q  <= 2'd0;
            map_x_q    <= 5'd0;
            map_y_q    <= 5'd0;
            xpos_q     <= START_X;
            ypos_q     <= START_Y;
            dir_q      <= START_DIR;
            moving_q   <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            req_dir_q  <= req_dir_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            step_q     <= step_d;
        end
    end

    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign direction = dir_q;
    assign moving    = moving_q;
    assign step      = step_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: table of step periods checked through a scoreboard queue,
// plus reset, mid-read reset and left-border sequences.
module tb_pacman_mover;

    logic       clk = 1'b0;
    logic       reset, ce, ce2, map_wall, map_wall2;
    logic [3:0] joy, joy2;
    logic [4:0] map_x, map_y, xpos, ypos, map_x2, map_y2, xpos2, ypos2;
    logic [1:0] direction, direction2;
    logic       moving, step, moving2, step2;

    logic wall_mem [0:31][0:31];

    int n_vec = 0;
    int n_bad = 0;
    int cyc, nst, lat;

    typedef struct {
        logic [3:0] j;
        logic [3:0] late_j;
        int w0x, w0y, w1x, w1y;
        int ax, ay, x, y, d, mov, ns, lat;
    } vec_t;

    vec_t vecs[15];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pacman_mover dut (
        .clk(clk), .reset(reset), .ce(ce), .joy(joy), .map_wall(map_wall),
        .map_x(map_x), .map_y(map_y), .xpos(xpos), .ypos(ypos),
        .direction(direction), .moving(moving), .step(step)
    );

    pacman_mover #(.START_X(5'd1)) dut2 (
        .clk(clk), .reset(reset), .ce(ce2), .joy(joy2), .map_wall(map_wall2),
        .map_x(map_x2), .map_y(map_y2), .xpos(xpos2), .ypos(ypos2),
        .direction(direction2), .moving(moving2), .step(step2)
    );

    // Registered map RAM model: data for the address seen at one edge appears after the next.
    always @(posedge clk) map_wall <= wall_mem[map_x][map_y];

    function automatic vec_t mk(input logic [3:0] j, input logic [3:0] lj,
                                input int w0x, input int w0y, input int w1x, input int w1y,
                                input int ax, input int ay, input int x, input int y,
                                input int d, input int mov, input int ns, input int lt);
        vec_t v;
        v.j = j; v.late_j = lj;
        v.w0x = w0x; v.w0y = w0y; v.w1x = w1x; v.w1y = w1y;
        v.ax = ax; v.ay = ay; v.x = x; v.y = y;
        v.d = d; v.mov = mov; v.ns = ns; v.lat = lt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step) begin
            nst++;
            if (lat == -99) lat = cyc;
        end
    endtask

    task automatic set_walls(input vec_t v);
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                wall_mem[a][b] = 1'b0;
        if (v.w0x != 0) wall_mem[v.w0x][v.w0y] = 1'b1;
        if (v.w1x != 0) wall_mem[v.w1x][v.w1y] = 1'b1;
    endtask

    task automatic ce_burst(output int ax, output int ay);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk) ce = 1'b1;
            if (k == 7) cyc = -1;
            tick();
            if (k == 7) begin
                ax = map_x;
                ay = map_y;
            end
            @(negedge clk) ce = 1'b0;
            if (k < 7) tick();
        end
    endtask

    task automatic run_period(input logic [3:0] j, input logic [3:0] lj, output int ax, output int ay);
        nst = 0;
        lat = -99;
        cyc = -100;
        @(negedge clk) joy = j;
        tick();
        @(negedge clk) joy = 4'd0;
        tick();
        ce_burst(ax, ay);
        for (int w = 0; w < 6; w++) begin
            tick();
            @(negedge clk) joy = (cyc == 1) ? lj : 4'd0;
        end
    endtask

    task automatic apply_vec(input int i);
        vec_t v, e;
        int ax, ay;
        v = vecs[i];
        set_walls(v);
        exp_q.push_back(v);
        run_period(v.j, v.late_j, ax, ay);
        e = exp_q.pop_front();
        chk($sformatf("v%0d.map_x", i), ax, e.ax);
        chk($sformatf("v%0d.map_y", i), ay, e.ay);
        chk($sformatf("v%0d.xpos", i), xpos, e.x);
        chk($sformatf("v%0d.ypos", i), ypos, e.y);
        chk($sformatf("v%0d.direction", i), direction, e.d);
        chk($sformatf("v%0d.moving", i), moving, e.mov);
        chk($sformatf("v%0d.step_pulses", i), nst, e.ns);
        if (e.ns > 0) begin
            if (e.lat >= 0) chk($sformatf("v%0d.step_latency", i), lat, e.lat);
            else            chk($sformatf("v%0d.step_after_frame", i), int'(lat > 0), 1);
        end
    endtask

    task automatic period2(input logic [3:0] j, output int ax, output int ns);
        ns = 0;
        @(negedge clk) joy2 = j;
        @(posedge clk);
        @(negedge clk) joy2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk) ce2 = 1'b1;
            @(posedge clk);
            #1;
            if (k == 7) ax = map_x2;
            @(negedge clk) ce2 = 1'b0;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            if (step2) ns++;
        end
    endtask

    initial begin
        int ax2, ns2;
        reset = 1'b1; ce = 1'b0; ce2 = 1'b0; joy = 4'd0; joy2 = 4'd0; map_wall2 = 1'b0;
        cyc = 0; nst = 0; lat = -99;
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                wall_mem[a][b] = 1'b0;

        //       j      late   walls              addr     pos      d  mov ns lat
        vecs[0]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    13, 23,  13, 23,  1, 1, 1, -1);
        vecs[1]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    12, 23,  12, 23,  1, 1, 1, -1);
        vecs[2]  = mk(4'b0001, 4'b0000, 14, 22, 13, 22, 14, 22, 13, 23,  1, 1, 1, 4);
        vecs[3]  = mk(4'b0000, 4'b0000, 14, 22, 13, 22, 13, 22, 12, 23,  1, 1, 1, 4);
        vecs[4]  = mk(4'b0000, 4'b0000, 14, 22, 13, 22, 12, 22, 12, 22,  0, 1, 1, 2);
        vecs[5]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    12, 21,  12, 21,  0, 1, 1, -1);
        vecs[6]  = mk(4'b0010, 4'b0000, 0, 0, 0, 0,    11, 21,  11, 21,  1, 1, 1, 2);
        vecs[7]  = mk(4'b0000, 4'b0000, 10, 21, 0, 0,  10, 21,  11, 21,  1, 0, 0, -1);
        vecs[8]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    10, 21,  10, 21,  1, 1, 1, -1);
        vecs[9]  = mk(4'b1100, 4'b0000, 0, 0, 0, 0,    10, 22,  10, 22,  2, 1, 1, 2);
        vecs[10] = mk(4'b1111, 4'b0000, 0, 0, 0, 0,    10, 21,  10, 21,  0, 1, 1, 2);
        vecs[11] = mk(4'b1000, 4'b0000, 11, 21, 0, 0,  11, 21,  10, 20,  0, 1, 1, 4);
        vecs[12] = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    11, 20,  11, 20,  3, 1, 1, 2);
        vecs[13] = mk(4'b0001, 4'b0010, 0, 0, 0, 0,    11, 19,  11, 19,  0, 1, 1, 2);
        vecs[14] = mk(4'b0000, 4'b0000, 0, 0, 0, 0,    10, 19,  10, 19,  1, 1, 1, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.xpos", xpos, 14);
        chk("rst.ypos", ypos, 23);
        chk("rst.direction", direction, 1);
        chk("rst.moving", moving, 0);
        chk("rst.step", step, 0);
        chk("rst.map_x", map_x, 0);
        chk("rst.map_y", map_y, 0);

        nst = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk) ce = 1'b1;
            tick();
            @(negedge clk) ce = 1'b0;
            tick();
        end
        chk("rst_hold.xpos", xpos, 14);
        chk("rst_hold.map_x", map_x, 0);
        chk("rst_hold.steps", nst, 0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 2; i++) apply_vec(i);

        // Request up from (12,23) is in REQ_DATA when reset hits.
        begin
            int ax, ay;
            set_walls(vecs[0]);
            nst = 0; lat = -99; cyc = -100;
            @(negedge clk) joy = 4'b0001;
            tick();
            @(negedge clk) joy = 4'd0;
            ce_burst(ax, ay);
            chk("mid.req_addr_y", ay, 22);
            tick();
            reset = 1'b1;
            #1;
            chk("mid.xpos", xpos, 14);
            chk("mid.ypos", ypos, 23);
            chk("mid.direction", direction, 1);
            chk("mid.moving", moving, 0);
            chk("mid.map_x", map_x, 0);
            chk("mid.map_y", map_y, 0);
            nst = 0;
            repeat (3) tick();
            chk("mid.steps", nst, 0);
            @(negedge clk) reset = 1'b0;
        end

        for (int i = 2; i < 15; i++) apply_vec(i);

        period2(4'b0000, ax2, ns2);
        chk("border.map_x", ax2, 0);
        chk("border.xpos", xpos2, 1);
        chk("border.moving", moving2, 0);
        chk("border.steps", ns2, 0);
        chk("border.direction", direction2, 1);
        period2(4'b1000, ax2, ns2);
        chk("border_turn.map_x", ax2, 2);
        chk("border_turn.xpos", xpos2, 2);
        chk("border_turn.direction", direction2, 3);
        chk("border_turn.moving", moving2, 1);
        chk("border_turn.steps", ns2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
